granule_sequencer: RTL and testbench
====================================

Name: granule_sequencer

Overview:
- Frame-level controller for the antialias → antialias_reorder datapath.
- Latches per-frame side info for both granules and drives the per-granule antialias configuration and the new_frame_start reset pulse.
- Generates read addresses into the dequantised-sample buffer and streams 576 samples per granule, honouring downstream stall.
- Counts reorder outputs, so granule 1 streaming starts only after granule 0 has fully drained.

Parameters:
- SAMPLES, 576, samples per granule per channel.
- NUM_GR, 2, granules per frame.
- DRAIN_TIMEOUT, 4096, idle cycles allowed in DRAIN with no dout_v before forced advance.

Ports:
- clk  input  1  system clock.
- rst  input  1  asynchronous, active-low reset.
- si_valid  input  1  one-cycle pulse: side info for a new frame is valid.
- wsf_in  input  2  window_switching_flag; bit g = granule g.
- block_type_in  input  4  block_type; bits [2g+1:2g] = granule g.
- mixed_block_flag_in  input  2  mixed_block_flag; bit g = granule g.
- samples_ready  input  1  level: sample buffer holds both granules of the current frame.
- stall  input  1  downstream not ready; suppresses reads.
- dout_v  input  1  valid strobe from antialias_reorder, one per output sample.
- rd_en  output  1  sample-buffer read enable (buffer read latency is 1 cycle).
- rd_gr  output  1  granule select for the buffer read.
- rd_addr  output  10  sample index for the buffer read.
- din_v  output  1  rd_en delayed 1 cycle; feeds antialias din_v.
- is_pos_out  output  10  rd_addr delayed 1 cycle, aligned with din_v.
- window_switching_flag_out  output  1  antialias config for the current granule.
- block_type_out  output  2  antialias config for the current granule.
- mixed_block_flag_out  output  1  antialias config for the current granule.
- new_frame_start  output  1  one-cycle pulse; resets antialias state before each granule.
- busy  output  1  high in every state except IDLE.
- frame_done  output  1  one-cycle pulse after the last granule drains.
- err_timeout  output  1  sticky; drain timeout occurred.
- err_overrun  output  1  sticky; si_valid arrived while busy.

Behaviour:
- Reset (rst=0, async): state=IDLE, all counters 0, every output 0.
- States: IDLE, WAIT_BUF, CONFIG, STREAM, DRAIN, DONE.
- IDLE:
  - On si_valid, latch wsf_in/block_type_in/mixed_block_flag_in into internal registers.
  - Set g=0 and clear both error flags in the same cycle → WAIT_BUF.
- WAIT_BUF: stays while samples_ready=0; when samples_ready=1 → CONFIG.
- CONFIG (exactly 1 cycle):
  - Config outputs are loaded from the granule-g fields and held constant until the next CONFIG.
  - new_frame_start=1 this cycle only. Clear in_cnt and out_cnt → STREAM.
- STREAM:
  - If stall=0: rd_en=1, rd_gr=g, rd_addr=in_cnt, then in_cnt++.
  - If stall=1: rd_en=0, in_cnt holds.
  - After the read with in_cnt=SAMPLES-1 is issued → DRAIN.
  - First rd_en occurs the cycle after the new_frame_start pulse.
- din_v and is_pos_out are registered copies of rd_en and rd_addr (1-cycle latency). din_v stays 1 cycle into DRAIN for the last sample.
- out_cnt increments on every dout_v in STREAM and DRAIN, because the datapath may emit before streaming ends.
- DRAIN:
  - When out_cnt reaches SAMPLES (including on the same edge that counts the final dout_v): if g=NUM_GR-1 → DONE, else g++ → CONFIG.
  - An idle counter resets on each dout_v and increments otherwise. At DRAIN_TIMEOUT: set err_timeout and advance exactly as if complete.
- DONE (1 cycle): frame_done=1 → IDLE. busy=0 from IDLE onward.
- si_valid outside IDLE: ignored, captured side info unchanged, err_overrun set.
- si_valid in the same cycle as the DONE→IDLE transition is not accepted; it counts as busy and sets err_overrun.
- dout_v outside STREAM/DRAIN is ignored.
- Counters saturate at SAMPLES; extra dout_v pulses do not wrap.
- rst asserted mid-frame: immediate return to reset values; no frame_done emitted.

Test Plan:
- Reset, then si_valid with wsf_in=2'b11, block_type_in=4'b0101, mixed=0, samples_ready=1, dout_v echoed 3 cycles after din_v, stall=0:
  - new_frame_start pulses twice.
  - rd_addr sweeps 0..575 for rd_gr=0, then for rd_gr=1.
  - Config outputs are wsf=1, bt=1 for both granules.
  - frame_done pulses once, about 1160 cycles after si_valid.
- Same frame with stall high for cycles 100–109 of STREAM: rd_en low for exactly 10 cycles, no address skipped or repeated, total din_v count is 1152.
- samples_ready held low for 50 cycles after si_valid: no rd_en and no new_frame_start until samples_ready rises. busy=1 throughout.
- Withhold dout_v entirely: after DRAIN_TIMEOUT idle cycles, err_timeout=1 and granule 1 starts with rd_addr=0. err_timeout clears on the next accepted si_valid.
- si_valid pulsed during granule 0 STREAM with different flags: err_overrun=1, and granule 1 config equals the originally latched values.
- Assert rst at rd_addr=300: all outputs 0 immediately. A fresh si_valid afterwards restarts from g=0, rd_addr=0.

Source files
------------

// File: rtl/granule_sequencer.sv
// rtl/granule_sequencer.sv - frame-level sequencer for the antialias -> antialias_reorder datapath
//
// Latches per-frame side info for both granules, loads the antialias config for
// each granule, streams SAMPLES read addresses per granule (honouring stall) and
// waits for the reorder stage to drain a granule before starting the next one.
//
// Ports:
//   clk, rst                     clock, asynchronous active-low reset
//   si_valid                     side info for a new frame is valid (pulse)
//   wsf_in / block_type_in /
//   mixed_block_flag_in          side info, granule g in bit g / bits [2g+1:2g]
//   samples_ready                sample buffer holds both granules
//   stall                        downstream not ready; suppresses reads
//   dout_v                       one strobe per sample leaving antialias_reorder
//   rd_en / rd_gr / rd_addr      sample-buffer read request (1-cycle read latency)
//   din_v / is_pos_out           read request delayed to line up with buffer data
//   *_out config                 antialias config for the granule in flight
//   new_frame_start              resets antialias state before each granule
//   busy / frame_done            activity and end-of-frame pulse
//   err_timeout / err_overrun    sticky error flags, cleared by an accepted frame
module granule_sequencer #(
  parameter int SAMPLES       = 576,
  parameter int NUM_GR        = 2,
  parameter int DRAIN_TIMEOUT = 4096
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       si_valid,
  input  logic [1:0] wsf_in,
  input  logic [3:0] block_type_in,
  input  logic [1:0] mixed_block_flag_in,
  input  logic       samples_ready,
  input  logic       stall,
  input  logic       dout_v,
  output logic       rd_en,
  output logic       rd_gr,
  output logic [9:0] rd_addr,
  output logic       din_v,
  output logic [9:0] is_pos_out,
  output logic       window_switching_flag_out,
  output logic [1:0] block_type_out,
  output logic       mixed_block_flag_out,
  output logic       new_frame_start,
  output logic       busy,
  output logic       frame_done,
  output logic       err_timeout,
  output logic       err_overrun
);

  localparam logic [2:0] S_IDLE     = 3'd0;
  localparam logic [2:0] S_WAIT_BUF = 3'd1;
  localparam logic [2:0] S_CONFIG   = 3'd2;
  localparam logic [2:0] S_STREAM   = 3'd3;
  localparam logic [2:0] S_DRAIN    = 3'd4;
  localparam logic [2:0] S_DONE     = 3'd5;

  localparam int IW = $clog2(DRAIN_TIMEOUT + 1);

  localparam logic [9:0]    CNT_FULL = 10'(SAMPLES);
  localparam logic [9:0]    CNT_LAST = 10'(SAMPLES - 1);
  localparam logic [IW-1:0] IDLE_MAX = IW'(DRAIN_TIMEOUT);
  localparam logic          GR_LAST  = 1'(NUM_GR - 1);

  logic [2:0]    r_state;
  logic          r_g;
  logic [1:0]    r_wsf;
  logic [3:0]    r_bt;
  logic [1:0]    r_mixed;
  logic [9:0]    r_in_cnt;
  logic [9:0]    r_out_cnt;
  logic [IW-1:0] r_idle;
  logic          r_din_v;
  logic [9:0]    r_is_pos;
  logic          r_cfg_wsf;
  logic [1:0]    r_cfg_bt;
  logic          r_cfg_mixed;
  logic          r_err_timeout;
  logic          r_err_overrun;

  logic          w_streaming;
  logic          w_rd_en;
  logic [9:0]    w_rd_addr;
  logic          w_out_inc;
  logic [9:0]    w_out_next;
  logic          w_drain_done;
  logic [IW-1:0] w_idle_next;
  logic          w_timeout;

  assign w_streaming = (r_state == S_STREAM);
  assign w_rd_en     = w_streaming && !stall;
  assign w_rd_addr   = w_streaming ? r_in_cnt : 10'd0;

  // Output count saturates; dout_v is only meaningful while a granule is in flight.
  assign w_out_inc    = dout_v && (w_streaming || r_state == S_DRAIN) && (r_out_cnt != CNT_FULL);
  assign w_out_next   = r_out_cnt + {9'd0, w_out_inc};
  // Completion looks at the post-increment count so the final dout_v advances on its own edge.
  assign w_drain_done = (w_out_next == CNT_FULL);
  assign w_idle_next  = dout_v ? '0 : r_idle + 1'b1;
  assign w_timeout    = !w_drain_done && (w_idle_next == IDLE_MAX);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state       <= S_IDLE;
      r_g           <= 1'b0;
      r_wsf         <= '0;
      r_bt          <= '0;
      r_mixed       <= '0;
      r_in_cnt      <= '0;
      r_out_cnt     <= '0;
      r_idle        <= '0;
      r_din_v       <= 1'b0;
      r_is_pos      <= '0;
      r_cfg_wsf     <= 1'b0;
      r_cfg_bt      <= '0;
      r_cfg_mixed   <= 1'b0;
      r_err_timeout <= 1'b0;
      r_err_overrun <= 1'b0;
    end else begin
      r_din_v  <= w_rd_en;
      r_is_pos <= w_rd_addr;

      // Any si_valid outside IDLE (including the DONE cycle) is rejected.
      if (si_valid && r_state != S_IDLE) begin
        r_err_overrun <= 1'b1;
      end

      case (r_state)
        S_IDLE: begin
          if (si_valid) begin
            r_wsf         <= wsf_in;
            r_bt          <= block_type_in;
            r_mixed       <= mixed_block_flag_in;
            r_g           <= 1'b0;
            r_err_timeout <= 1'b0;
            r_err_overrun <= 1'b0;
            r_state       <= S_WAIT_BUF;
          end
        end
        S_WAIT_BUF: begin
          if (samples_ready) begin
            r_state <= S_CONFIG;
          end
        end
        S_CONFIG: begin
          r_cfg_wsf   <= r_wsf[r_g];
          r_cfg_bt    <= r_g ? r_bt[3:2] : r_bt[1:0];
          r_cfg_mixed <= r_mixed[r_g];
          r_in_cnt    <= '0;
          r_out_cnt   <= '0;
          r_idle      <= '0;
          r_state     <= S_STREAM;
        end
        S_STREAM: begin
          r_out_cnt <= w_out_next;
          if (w_rd_en) begin
            if (r_in_cnt != CNT_FULL) begin
              r_in_cnt <= r_in_cnt + 10'd1;
            end
            if (r_in_cnt == CNT_LAST) begin
              r_state <= S_DRAIN;
            end
          end
        end
        S_DRAIN: begin
          r_out_cnt <= w_out_next;
          r_idle    <= w_idle_next;
          if (w_drain_done || w_timeout) begin
            if (w_timeout) begin
              r_err_timeout <= 1'b1;
            end
            if (r_g == GR_LAST) begin
              r_state <= S_DONE;
            end else begin
              r_g     <= r_g + 1'b1;
              r_state <= S_CONFIG;
            end
          end
        end
        S_DONE: begin
          r_state <= S_IDLE;
        end
        default: begin
          r_state <= S_IDLE;
        end
      endcase
    end
  end

  assign rd_en                     = w_rd_en;
  assign rd_gr                     = w_streaming & r_g;
  assign rd_addr                   = w_rd_addr;
  assign din_v                     = r_din_v;
  assign is_pos_out                = r_is_pos;
  assign window_switching_flag_out = r_cfg_wsf;
  assign block_type_out            = r_cfg_bt;
  assign mixed_block_flag_out      = r_cfg_mixed;
  assign new_frame_start           = (r_state == S_CONFIG);
  assign busy                      = (r_state != S_IDLE);
  assign frame_done                = (r_state == S_DONE);
  assign err_timeout               = r_err_timeout;
  assign err_overrun               = r_err_overrun;

endmodule

// File: tb/tb_granule_sequencer.sv
// tb/tb_granule_sequencer.sv - randomized self-checking bench for granule_sequencer
`timescale 1ns/1ps
module tb_granule_sequencer;

  localparam int SAMPLES = 576;
  localparam int NUM_GR  = 2;
  localparam int TMO     = 4096;

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic       si_valid = 1'b0;
  logic [1:0] wsf_in = '0;
  logic [3:0] block_type_in = '0;
  logic [1:0] mixed_block_flag_in = '0;
  logic       samples_ready = 1'b0;
  logic       stall = 1'b0;
  logic       dout_v = 1'b0;
  logic       rd_en, rd_gr, din_v;
  logic [9:0] rd_addr, is_pos_out;
  logic       wsf_out, mixed_out;
  logic [1:0] bt_out;
  logic       new_frame_start, busy, frame_done, err_timeout, err_overrun;
  logic [31:0] all_outs;

  always #5 clk = ~clk;

  granule_sequencer #(.SAMPLES(SAMPLES), .NUM_GR(NUM_GR), .DRAIN_TIMEOUT(TMO)) dut (
    .clk(clk), .rst(rst), .si_valid(si_valid), .wsf_in(wsf_in),
    .block_type_in(block_type_in), .mixed_block_flag_in(mixed_block_flag_in),
    .samples_ready(samples_ready), .stall(stall), .dout_v(dout_v),
    .rd_en(rd_en), .rd_gr(rd_gr), .rd_addr(rd_addr), .din_v(din_v),
    .is_pos_out(is_pos_out), .window_switching_flag_out(wsf_out),
    .block_type_out(bt_out), .mixed_block_flag_out(mixed_out),
    .new_frame_start(new_frame_start), .busy(busy), .frame_done(frame_done),
    .err_timeout(err_timeout), .err_overrun(err_overrun)
  );

  assign all_outs = {rd_en, rd_gr, rd_addr, din_v, is_pos_out, wsf_out, bt_out, mixed_out,
                     new_frame_start, busy, frame_done, err_timeout, err_overrun};

  int n_checks = 0;
  int n_errors = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Stimulus control
  int   cyc = 0;
  int   base = 0;
  int   st_mode = 0;   // 0 no stall, 1 stall at frame cycles 102..111, 2 random
  int   dly = 3;       // dout_v echo distance from din_v, cycles
  bit   den = 1'b1;    // echo din_v as dout_v
  bit   spur = 1'b0;   // inject random extra dout_v pulses
  logic [7:0] hist = '0;

  always @(negedge clk) hist = {hist[6:0], din_v};

  // Reference model: phases of a frame, read/position expectations as queues.
  typedef enum int {P_IDLE, P_WAIT, P_CFG, P_STREAM, P_DRAIN, P_DONE} phase_t;
  phase_t     m_ph = P_IDLE;
  int         m_g = 0, m_rd = 0, m_out = 0, m_idle = 0;
  bit         m_to = 0, m_ov = 0, m_din = 0;
  logic [1:0] m_w = '0, m_m = '0;
  logic [3:0] m_b = '0;
  logic       m_cw = 0, m_cm = 0;
  logic [1:0] m_cb = '0;
  int         exp_rd[$];
  int         exp_pos[$];

  always @(posedge clk or negedge rst) begin
    if (!rst) begin
      m_ph = P_IDLE; m_g = 0; m_rd = 0; m_out = 0; m_idle = 0;
      m_to = 0; m_ov = 0; m_din = 0;
      m_w = '0; m_b = '0; m_m = '0; m_cw = 0; m_cb = '0; m_cm = 0;
      exp_rd.delete(); exp_pos.delete();
    end else begin
      m_din = (m_ph == P_STREAM) && !stall;
      if (si_valid && m_ph != P_IDLE) m_ov = 1;
      case (m_ph)
        P_IDLE: if (si_valid) begin
          m_w = wsf_in; m_b = block_type_in; m_m = mixed_block_flag_in;
          m_g = 0; m_to = 0; m_ov = 0; m_ph = P_WAIT;
          for (int g = 0; g < NUM_GR; g++)
            for (int a = 0; a < SAMPLES; a++) begin
              exp_rd.push_back(g * 1024 + a);
              exp_pos.push_back(a);
            end
        end
        P_WAIT: if (samples_ready) m_ph = P_CFG;
        P_CFG: begin
          m_cw = m_w[m_g]; m_cb = m_b[2*m_g +: 2]; m_cm = m_m[m_g];
          m_rd = 0; m_out = 0; m_idle = 0; m_ph = P_STREAM;
        end
        P_STREAM: begin
          if (dout_v && m_out < SAMPLES) m_out++;
          if (!stall) m_rd++;
          if (m_rd == SAMPLES) m_ph = P_DRAIN;
        end
        P_DRAIN: begin
          if (dout_v && m_out < SAMPLES) m_out++;
          m_idle = dout_v ? 0 : m_idle + 1;
          if (m_out == SAMPLES || m_idle == TMO) begin
            if (m_out != SAMPLES) m_to = 1;
            if (m_g == NUM_GR - 1) m_ph = P_DONE;
            else begin m_g++; m_ph = P_CFG; end
          end
        end
        default: m_ph = P_IDLE;
      endcase
    end
  end

  // Per-cycle comparison and event bookkeeping
  int done_cnt = 0, done_cyc = 0, din_cnt = 0, stall_lo = 0, nfs_cnt = 0;
  int nfs_first = 0, first_rd = 0;
  bit want_first = 0;

  always @(negedge clk) begin
    int e;
    if (rst) begin
      check("busy", busy, m_ph != P_IDLE);
      check("new_frame_start", new_frame_start, m_ph == P_CFG);
      check("frame_done", frame_done, m_ph == P_DONE);
      check("rd_en", rd_en, (m_ph == P_STREAM) && !stall);
      check("din_v", din_v, m_din);
      check("err_timeout", err_timeout, m_to);
      check("err_overrun", err_overrun, m_ov);
      check("config", {wsf_out, bt_out, mixed_out}, {m_cw, m_cb, m_cm});
      if (rd_en) begin
        if (exp_rd.size() == 0) check("rd_extra", 1, 0);
        else begin
          e = exp_rd.pop_front();
          check("rd_gr_addr", {rd_gr, rd_addr}, e);
        end
        if (want_first) begin first_rd = {rd_gr, rd_addr}; want_first = 0; end
      end
      if (din_v) begin
        din_cnt++;
        if (exp_pos.size() == 0) check("din_extra", 1, 0);
        else begin
          e = exp_pos.pop_front();
          check("is_pos_out", is_pos_out, e);
        end
      end
      if (frame_done) begin
        done_cnt++; done_cyc = cyc - base;
        check("reads_left_at_done", exp_rd.size(), 0);
      end
      if (m_ph == P_STREAM && !rd_en) stall_lo++;
      if (new_frame_start) begin
        if (nfs_first < 0) nfs_first = cyc - base;
        nfs_cnt++;
      end
    end
  end

  task automatic tick();
    @(posedge clk); #1;
    cyc++;
    si_valid = 1'b0;
    case (st_mode)
      1:       stall = (cyc - base >= 102) && (cyc - base <= 111);
      2:       stall = ($urandom_range(0, 3) == 0);
      default: stall = 1'b0;
    endcase
    dout_v = (den && hist[dly-1]) || (spur && $urandom_range(0, 39) == 0);
  endtask

  task automatic run_frame(input logic [1:0] w, input logic [3:0] b, input logic [1:0] m,
                           input int rdy_dly, input int ov_at, input bit si_done, input int rst_at);
    int d0;
    tick();
    wsf_in = w; block_type_in = b; mixed_block_flag_in = m;
    si_valid = 1'b1; samples_ready = 1'b0;
    tick();
    base = cyc;
    nfs_first = -1;
    samples_ready = (rdy_dly <= 0);
    d0 = done_cnt;
    for (int k = 0; k < 20000; k++) begin
      if (done_cnt != d0) break;
      tick();
      samples_ready = (cyc - base >= rdy_dly);
      if (cyc - base == ov_at) begin
        wsf_in = ~w; block_type_in = ~b; mixed_block_flag_in = ~m; si_valid = 1'b1;
      end
      if (si_done && m_ph == P_DONE) si_valid = 1'b1;
      if (rst_at >= 0 && m_ph == P_STREAM && m_g == 0 && m_rd == rst_at) begin
        stall = 1'b0; #1;
        check("pre_reset_rd_addr", rd_addr, rst_at);
        rst = 1'b0; #1;
        check("mid_frame_reset_outputs", all_outs, 0);
        samples_ready = 1'b0;
        @(posedge clk); #1; @(posedge clk); #1;
        rst = 1'b1;
        return;
      end
    end
    if (done_cnt == d0) check("frame_done_timeout", 0, 1);
    repeat (10) tick();
  endtask

  initial begin
    int n0, d0, s0;
    repeat (3) @(posedge clk);
    #1;
    check("reset_outputs", all_outs, 0);
    rst = 1'b1;

    // Plain frame, echo distance 3
    n0 = nfs_cnt;
    run_frame(2'b11, 4'b0101, 2'b00, 0, -1, 0, -1);
    check("t1_latency", done_cyc, 1163);
    check("t1_new_frame_pulses", nfs_cnt - n0, 2);
    check("t1_config", {wsf_out, bt_out, mixed_out}, 4'b1010);

    // Ten stall cycles inside granule 0
    st_mode = 1; d0 = din_cnt; s0 = stall_lo;
    run_frame(2'b11, 4'b0101, 2'b00, 0, -1, 0, -1);
    check("t2_latency", done_cyc, 1173);
    check("t2_din_count", din_cnt - d0, 1152);
    check("t2_stalled_cycles", stall_lo - s0, 10);

    // Buffer not ready for 50 cycles
    st_mode = 0;
    run_frame(2'b11, 4'b0101, 2'b00, 50, -1, 0, -1);
    check("t3_first_new_frame", nfs_first, 51);
    check("t3_latency", done_cyc, 1213);

    // No dout_v at all: both granules time out
    den = 1'b0;
    run_frame(2'b00, 4'b1110, 2'b01, 0, -1, 0, -1);
    check("t4_err_timeout", err_timeout, 1);
    check("t4_latency", done_cyc, 9347);
    den = 1'b1;
    run_frame(2'b00, 4'b1110, 2'b01, 0, -1, 0, -1);
    check("t4_timeout_cleared", err_timeout, 0);

    // si_valid during granule 0 stream must not disturb the latched side info
    run_frame(2'b01, 4'b1000, 2'b10, 0, 200, 0, -1);
    check("t5_err_overrun", err_overrun, 1);
    check("t5_gr1_config", {wsf_out, bt_out, mixed_out}, 4'b0101);

    // si_valid on the DONE cycle is rejected
    run_frame(2'b10, 4'b0111, 2'b11, 0, -1, 1, -1);
    check("t6_busy_after_done", busy, 0);
    check("t6_err_overrun", err_overrun, 1);

    // Reset mid-stream, then a fresh frame restarts from granule 0, address 0
    run_frame(2'b11, 4'b0101, 2'b00, 0, -1, 0, 300);
    want_first = 1; first_rd = -1; d0 = done_cnt;
    run_frame(2'b01, 4'b0100, 2'b01, 0, -1, 0, -1);
    check("t7_first_read", first_rd, 0);
    check("t7_latency", done_cyc, 1163);
    check("t7_one_frame_done", done_cnt - d0, 1);

    // Randomized frames: random stall, echo distance, ready delay, stray dout_v
    st_mode = 2; spur = 1'b1;
    for (int f = 0; f < 4; f++) begin
      dly = $urandom_range(1, 6);
      run_frame(2'($urandom), 4'($urandom), 2'($urandom), $urandom_range(0, 20), -1, 0, -1);
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

  initial begin
    #2ms;
    $display("FAIL watchdog: simulation did not complete, got timeout, expected finish");
    $fatal(1);
  end

endmodule
